// File: rtl/gpio_frame_packer.sv
// Packs the strobed 1-bit GPIO pixel stream MSB-first into words and writes them to a frame RAM.
// Latency: a word is presented on the write port 1 cycle after its final pixel strobe.
// Backpressure: the pending word holds until wr_ready; a newer word overwrites it and sets sticky overflow.
module gpio_frame_packer #(
    parameter int IMG_W  = 240,
    parameter int IMG_H  = 240,
    parameter int WORD_W = 8,
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              GPIO,
    input  logic              GPIOBoolean,
    output logic              wr_en,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_data,
    output logic [7:0]        col,
    output logic [7:0]        row,
    output logic              capturing,
    output logic              frame_done,
    output logic              overflow
);

    localparam int              BW       = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [15:0]     TOTAL    = 16'(IMG_W * IMG_H);
    localparam logic [BW-1:0]   LAST_BIT = BW'(WORD_W - 1);
    localparam logic [7:0]      LAST_COL = 8'(IMG_W - 1);
    localparam logic [7:0]      LAST_ROW = 8'(IMG_H - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [WORD_W-1:0]   shreg;
    logic [BW-1:0]       bit_cnt;
    logic [15:0]         pix_cnt;
    logic [ADDR_W-1:0]   word_cnt;

    logic                pix_acc;
    logic                word_done;
    logic                wr_acc;
    logic                arm;
    logic                frame_end;
    logic [WORD_W-1:0]   word_nxt;

    // Event decode: pixels are taken only while capturing and until the frame is full.
    always_comb begin
        pix_acc   = (state == S_CAPTURE) && GPIOBoolean && (pix_cnt != TOTAL);
        word_done = pix_acc && (bit_cnt == LAST_BIT);
        wr_acc    = wr_en && wr_ready;
        arm       = (state != S_CAPTURE) && start;
        frame_end = (state == S_CAPTURE) && (pix_cnt == TOTAL) && wr_acc;
        word_nxt  = {shreg[WORD_W-2:0], GPIO};
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic: start arms capture from IDLE or DONE; last accepted word ends the frame.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start)     state_nxt = S_CAPTURE;
            S_CAPTURE: if (frame_end) state_nxt = S_DONE;
            S_DONE:    if (start)     state_nxt = S_CAPTURE;
            default:                  state_nxt = S_IDLE;
        endcase
    end

    // State-decoded status outputs.
    always_comb begin
        capturing  = (state == S_CAPTURE);
        frame_done = (state == S_DONE);
    end

    // Pixel path, raster position and write port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg    <= '0;
            bit_cnt  <= '0;
            pix_cnt  <= '0;
            word_cnt <= '0;
            col      <= '0;
            row      <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            overflow <= 1'b0;
        end else begin
            if (arm) begin
                shreg    <= '0;
                bit_cnt  <= '0;
                pix_cnt  <= '0;
                word_cnt <= '0;
                col      <= '0;
                row      <= '0;
                wr_addr  <= '0;
                overflow <= 1'b0;
            end else if (pix_acc) begin
                shreg   <= word_nxt;
                bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
                pix_cnt <= pix_cnt + 16'd1;
                if (col == LAST_COL) begin
                    col <= '0;
                    row <= (row == LAST_ROW) ? 8'd0 : row + 8'd1;
                end else begin
                    col <= col + 8'd1;
                end
                if (word_done) word_cnt <= word_cnt + 1'b1;
            end

            // A completing word always wins the port; losing an unaccepted word is flagged.
            if (word_done) begin
                wr_en   <= 1'b1;
                wr_data <= word_nxt;
                wr_addr <= word_cnt;
                if (wr_en && !wr_ready) overflow <= 1'b1;
            end else if (wr_acc) begin
                wr_en <= 1'b0;
            end
        end
    end

endmodule
